display_nhex: RTL and testbench

- Parametrised successor to the fixed 8-digit hex display driver: time-multiplexed, common-anode 7-segment scanner for NUM_DIGITS hex digits.
- Adds per-digit decimal points, a per-digit enable mask, optional leading-zero blanking, an anti-ghosting guard interval and tear-free frame-synchronous input latching.
- Sits between game/debug logic and the board SEG/AN pins on the 25 MHz system clock.

---
 rtl/display_nhex.sv | 149 ++++++++++++++
 tb/tb_display_nhex.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_nhex.sv
// Time-multiplexed common-anode 7-segment scanner for NUM_DIGITS hex digits with
// per-digit decimal point, enable mask, leading-zero blanking, ghost guard and frame-synchronous latching.
`timescale 1ns/1ps
module display_nhex #(
    parameter int NUM_DIGITS       = 8,
    parameter int CYCLES_PER_DIGIT = 25000,
    parameter int GUARD            = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   strobe,
    output logic                    frame_start
);
    localparam int CNT_W = $clog2(CYCLES_PER_DIGIT);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

    // Active-low segment pattern, bit 6 = G ... bit 0 = A.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
    logic                    blz_sh_q, blz_sh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   strobe_q, strobe_d;
    logic                    frame_start_q, frame_start_d;

    logic                    latch;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_nib;

    assign latch = (idx_q == '0) && (cnt_q == '0);

    // Slot counter and digit index.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Shadow copies only move at the frame boundary so a frame never mixes old and new data.
    always_comb begin
        data_sh_d = data_sh_q;
        dp_sh_d   = dp_sh_q;
        en_sh_d   = en_sh_q;
        blz_sh_d  = blz_sh_q;
        if (latch) begin
            data_sh_d = data;
            dp_sh_d   = dp;
            en_sh_d   = digit_en;
            blz_sh_d  = blank_lz;
        end
    end

    // A digit is a leading zero when it and every more-significant digit is 0 with no dp lit.
    always_comb begin : blank_calc
        logic zero_hi;
        zero_hi    = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_hi       = zero_hi & (data_sh_q[4*i +: 4] == 4'h0) & ~dp_sh_q[i];
            blank_mask[i] = blz_sh_q & zero_hi;
        end
    end

    assign cur_nib = data_sh_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        seg_d         = 7'h7F;
        dp_n_d        = 1'b1;
        strobe_d      = '1;
        frame_start_d = latch;
        if (cnt_q >= GUARD_C && en_sh_q[idx_q] && !blank_mask[idx_q]) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                strobe_d[i] = (idx_q != IDX_W'(i));
            end
            seg_d  = hex_to_seg(cur_nib);
            dp_n_d = ~dp_sh_q[idx_q];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            data_sh_q     <= '0;
            dp_sh_q       <= '0;
            en_sh_q       <= '0;
            blz_sh_q      <= 1'b0;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
            strobe_q      <= '1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            data_sh_q     <= data_sh_d;
            dp_sh_q       <= dp_sh_d;
            en_sh_q       <= en_sh_d;
            blz_sh_q      <= blz_sh_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            strobe_q      <= strobe_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign strobe      = strobe_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_display_nhex.sv
// Self-checking bench for display_nhex: a frame-position model pushes expected outputs
// into a scoreboard queue every edge; feature tasks pop and compare, then add scenario checks.
`timescale 1ns/1ps
module tb_display_nhex;
    localparam int ND    = 4;
    localparam int CPD   = 8;
    localparam int G     = 2;
    localparam int FRAME = ND * CPD;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp_n;
        logic [3:0] strobe;
        logic       fs;
    } out_t;

    localparam out_t RST_OUT = '{seg: 7'h7F, dp_n: 1'b1, strobe: 4'hF, fs: 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  strobe;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    out_t exp_q[$];

    // Reference model state: position inside the frame plus the values latched at its start.
    int          m_pos;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic        m_blz;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    display_nhex #(.NUM_DIGITS(ND), .CYCLES_PER_DIGIT(CPD), .GUARD(G)) dut (
        .clk(clk),
        .reset(reset),
        .data(data),
        .dp(dp),
        .digit_en(digit_en),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp_n(dp_n),
        .strobe(strobe),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic out_t cur_out();
        return '{seg: seg, dp_n: dp_n, strobe: strobe, fs: frame_start};
    endfunction

    function automatic logic lz_dark(input int slot);
        return (slot > 0) && m_blz && ((m_data >> (4 * slot)) == 16'h0) && ((m_dp >> slot) == 4'h0);
    endfunction

    function automatic out_t model_out();
        out_t o;
        int   slot;
        int   off;
        o    = '{seg: 7'h7F, dp_n: 1'b1, strobe: 4'hF, fs: (m_pos == 0)};
        slot = m_pos / CPD;
        off  = m_pos % CPD;
        if (off >= G && m_en[slot] && !lz_dark(slot)) begin
            o.strobe = ~(4'b0001 << slot);
            o.seg    = hex_tbl[m_data[slot*4 +: 4]];
            o.dp_n   = ~m_dp[slot];
        end
        return o;
    endfunction

    function automatic void model_reset();
        m_pos  = 0;
        m_data = '0;
        m_dp   = '0;
        m_en   = '0;
        m_blz  = 1'b0;
        exp_q.delete();
    endfunction

    // Push what the next edge must produce, step the model, then clock to just after the edge.
    task automatic advance();
        exp_q.push_back(model_out());
        if (m_pos == 0) begin
            m_data = data;
            m_dp   = dp;
            m_en   = digit_en;
            m_blz  = blank_lz;
        end
        m_pos = (m_pos + 1) % FRAME;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t got, exp;
        got = cur_out();
        total++;
        if (got !== RST_OUT) begin
            bad++;
            $display("FAIL reset_values got=%b want=%b", got, RST_OUT);
        end
        #10 reset = 1'b0;
        advance();
        got = cur_out();
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_edge1 got=%b want=%b", got, exp);
        end
        total++;
        if (got.fs !== 1'b1) begin
            bad++;
            $display("FAIL first_frame_start got=%b want=1", got.fs);
        end
    endtask

    task automatic test_scan();
        out_t got, exp;
        int   last_fs = -1;
        bit   d0_done = 0, d3_done = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL scan c=%0d got=%b want=%b", c, got, exp);
            end
            if (exp.strobe == 4'b1110 && !d0_done) begin
                d0_done = 1;
                total++;
                if (got.seg !== 7'b0011001) begin
                    bad++;
                    $display("FAIL scan_digit0 got=%b want=0011001", got.seg);
                end
            end
            if (exp.strobe == 4'b0111 && !d3_done) begin
                d3_done = 1;
                total++;
                if (got.seg !== 7'b1111001) begin
                    bad++;
                    $display("FAIL scan_digit3 got=%b want=1111001", got.seg);
                end
            end
            if (got.fs === 1'b1) begin
                if (last_fs >= 0) begin
                    total++;
                    if (c - last_fs != FRAME) begin
                        bad++;
                        $display("FAIL frame_period got=%0d want=%0d", c - last_fs, FRAME);
                    end
                end
                last_fs = c;
            end
        end
    endtask

    task automatic test_tear_free();
        out_t got, exp;
        bit   changed = 0, nf = 0;
        bit   d2_done = 0, d3_done = 0, nd0_done = 0;
        int   n = ((17 - m_pos + FRAME) % FRAME) + (FRAME - 17) + FRAME;
        for (int c = 0; c < n; c++) begin
            if (m_pos == 17 && !changed) begin
                data    = 16'hABCD;
                changed = 1;
            end
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL tear c=%0d got=%b want=%b", c, got, exp);
            end
            if (changed && exp.fs) nf = 1;
            if (changed && !nf && exp.strobe == 4'b1011 && !d2_done) begin
                d2_done = 1;
                total++;
                if (got.seg !== 7'b0100100) begin
                    bad++;
                    $display("FAIL tear_old_digit2 got=%b want=0100100", got.seg);
                end
            end
            if (changed && !nf && exp.strobe == 4'b0111 && !d3_done) begin
                d3_done = 1;
                total++;
                if (got.seg !== 7'b1111001) begin
                    bad++;
                    $display("FAIL tear_old_digit3 got=%b want=1111001", got.seg);
                end
            end
            if (nf && exp.strobe == 4'b1110 && !nd0_done) begin
                nd0_done = 1;
                total++;
                if (got.seg !== 7'b0100001) begin
                    bad++;
                    $display("FAIL tear_new_digit0 got=%b want=0100001", got.seg);
                end
            end
        end
    endtask

    task automatic test_blanking();
        out_t got, exp;
        int   fr = 0;
        int   dark_hits1 = 0, dark_hits2 = 0;
        bit   d1_done = 0, d0_done = 0, d2_done = 0;
        int   n = ((FRAME - m_pos) % FRAME) + 2 * FRAME;
        data     = 16'h0040;
        dp       = 4'b0000;
        digit_en = 4'hF;
        blank_lz = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (m_pos == 0 && fr == 1) dp = 4'b0100;
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            if (exp.fs) fr++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL blank c=%0d got=%b want=%b", c, got, exp);
            end
            if (fr == 1) begin
                if (got.strobe == 4'b0111 || got.strobe == 4'b1011) dark_hits1++;
                if (exp.strobe == 4'b1101 && !d1_done) begin
                    d1_done = 1;
                    total++;
                    if (got.seg !== 7'b0011001) begin
                        bad++;
                        $display("FAIL blank_digit1 got=%b want=0011001", got.seg);
                    end
                end
                if (exp.strobe == 4'b1110 && !d0_done) begin
                    d0_done = 1;
                    total++;
                    if (got.seg !== 7'b1000000) begin
                        bad++;
                        $display("FAIL blank_digit0 got=%b want=1000000", got.seg);
                    end
                end
            end
            if (fr == 2) begin
                if (got.strobe == 4'b0111) dark_hits2++;
                if (exp.strobe == 4'b1011 && !d2_done) begin
                    d2_done = 1;
                    total++;
                    if ({got.seg, got.dp_n} !== {7'b1000000, 1'b0}) begin
                        bad++;
                        $display("FAIL blank_dp_digit2 got=%b/%b want=1000000/0", got.seg, got.dp_n);
                    end
                end
            end
        end
        total++;
        if (dark_hits1 != 0) begin
            bad++;
            $display("FAIL blank_lz_dark got=%0d lit cycles want=0", dark_hits1);
        end
        total++;
        if (dark_hits2 != 0) begin
            bad++;
            $display("FAIL blank_dp_digit3_dark got=%0d lit cycles want=0", dark_hits2);
        end
    endtask

    task automatic test_enable();
        out_t got, exp;
        int   fr = 0;
        int   off_hits = 0, n1 = 0, n3 = 0;
        int   n = ((FRAME - m_pos) % FRAME) + FRAME;
        data     = 16'h1234;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        digit_en = 4'b1010;
        for (int c = 0; c < n; c++) begin
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            if (exp.fs) fr++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL enable c=%0d got=%b want=%b", c, got, exp);
            end
            if (fr == 1) begin
                if (got.strobe == 4'b1110 || got.strobe == 4'b1011) off_hits++;
                if (got.strobe == 4'b1101) n1++;
                if (got.strobe == 4'b0111) n3++;
            end
        end
        total++;
        if (off_hits != 0) begin
            bad++;
            $display("FAIL enable_masked got=%0d lit cycles want=0", off_hits);
        end
        total++;
        if (n1 != CPD - G || n3 != CPD - G) begin
            bad++;
            $display("FAIL enable_slot_len got=%0d,%0d want=%0d", n1, n3, CPD - G);
        end
    endtask

    task automatic test_guard();
        out_t got, exp;
        int   fr = 0;
        int   multi = 0, dark = 0, low;
        int   n = ((FRAME - m_pos) % FRAME) + FRAME;
        digit_en = 4'hF;
        for (int c = 0; c < n; c++) begin
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            if (exp.fs) fr++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL guard c=%0d got=%b want=%b", c, got, exp);
            end
            if (fr == 1) begin
                low = 0;
                for (int b = 0; b < ND; b++) if (got.strobe[b] === 1'b0) low++;
                if (low > 1) multi++;
                if (got.strobe === 4'hF) dark++;
            end
        end
        total++;
        if (multi != 0) begin
            bad++;
            $display("FAIL guard_two_low got=%0d cycles want=0", multi);
        end
        total++;
        if (dark != ND * G) begin
            bad++;
            $display("FAIL guard_dark_cycles got=%0d want=%0d", dark, ND * G);
        end
    endtask

    task automatic test_reset_mid();
        out_t got, exp;
        int   n = (13 - m_pos + FRAME) % FRAME;
        for (int c = 0; c < n; c++) begin
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL pre_reset c=%0d got=%b want=%b", c, got, exp);
            end
        end
        #2 reset = 1'b1;
        #1;
        got = cur_out();
        total++;
        if (got !== RST_OUT) begin
            bad++;
            $display("FAIL reset_async got=%b want=%b", got, RST_OUT);
        end
        model_reset();
        data = 16'h00F0;
        #2 reset = 1'b0;
        for (int c = 0; c < FRAME + CPD; c++) begin
            advance();
            got = cur_out();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL post_reset c=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 0) begin
                total++;
                if (got.fs !== 1'b1) begin
                    bad++;
                    $display("FAIL post_reset_frame_start got=%b want=1", got.fs);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        data     = 16'h1234;
        dp       = 4'b0000;
        digit_en = 4'hF;
        blank_lz = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_scan();
        test_tear_free();
        test_blanking();
        test_enable();
        test_guard();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
